seq_alu: RTL

//  Parametrised multi-cycle ALU with a start/busy/done handshake; sits between control_unit and the register file.

---
 rtl/seq_alu_if.sv | 40 ++++
 rtl/seq_alu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between control_unit and seq_alu
// Purpose: carries one ALU request (operands, opcode, SREG snapshot) towards
//   the ALU and its busy/done status, result and updated SREG back.
// Signals:
//   start      request strobe, honoured only while busy=0
//   op         4-bit opcode
//   rd, rr     DATA_WIDTH operands
//   cin_en     ADD/SUB consume flags_in[C]
//   cout_en    ADD/SUB write C (else C copied from flags_in)
//   flags_in   SREG snapshot {I,T,H,S,V,N,Z,C}
//   busy       multiply in progress
//   done       one-cycle pulse, result/flags_out valid
//   result     2*DATA_WIDTH result
//   flags_out  updated SREG
// Modports: master drives the request side, slave is the ALU.
interface seq_alu_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    start;
  logic [3:0]              op;
  logic [DATA_WIDTH-1:0]   rd;
  logic [DATA_WIDTH-1:0]   rr;
  logic                    cin_en;
  logic                    cout_en;
  logic [7:0]              flags_in;
  logic                    busy;
  logic                    done;
  logic [2*DATA_WIDTH-1:0] result;
  logic [7:0]              flags_out;

  modport master (
    output start, op, rd, rr, cin_en, cout_en, flags_in,
    input  busy, done, result, flags_out
  );

  modport slave (
    input  start, op, rd, rr, cin_en, cout_en, flags_in,
    output busy, done, result, flags_out
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with start/busy/done handshake
// Purpose: single-cycle arithmetic/logic/shift ops with registered result and
//   SREG update, plus iterative shift-add multiply (MUL/MULS/MULSU) producing
//   an exact 2*DATA_WIDTH product, one partial product per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    seq_alu_if.slave: start/op/rd/rr/cin_en/cout_en/flags_in in,
//          busy/done/result/flags_out out
module seq_alu #(
  parameter int DATA_WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NEG   = 4'd5;
  localparam logic [3:0] OP_COM   = 4'd6;
  localparam logic [3:0] OP_LSR   = 4'd7;
  localparam logic [3:0] OP_ASR   = 4'd8;
  localparam logic [3:0] OP_ROR   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULS  = 4'd11;
  localparam logic [3:0] OP_MULSU = 4'd12;

  localparam int F_C = 0;
  localparam int F_H = 5;
  localparam int F_T = 6;
  localparam int F_I = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          accept;
  logic          is_mul_op;

  // multiply datapath
  logic [CW-1:0] cnt;
  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] pp;
  logic          neg_last;
  logic [7:0]    mul_flags_base;

  // single-cycle datapath
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  r;
  logic          cin;
  logic          c_f;
  logic          h_f;
  logic          v_f;
  logic          n_f;
  logic          z_f;
  logic [W:0]    sum_w;
  logic [4:0]    sum_n;
  logic [7:0]    alu_flags;
  logic [PW-1:0] alu_result;

  // output registers
  logic          done_q;
  logic [PW-1:0] result_q;
  logic [7:0]    flags_q;

  assign is_mul_op = (bus.op == OP_MUL) || (bus.op == OP_MULS) || (bus.op == OP_MULSU);
  // DONE is not busy, so a new request can be taken in the done cycle.
  assign accept    = bus.start && (state != S_MUL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: state_next = (accept && is_mul_op) ? S_MUL : S_IDLE;
      S_MUL:          state_next = (cnt == '0) ? S_DONE : S_MUL;
      default:        state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state == S_MUL);
    bus.done      = done_q;
    bus.result    = result_q;
    bus.flags_out = flags_q;
  end

  // Single-cycle ops evaluated straight from the request so they can be
  // registered on the accepting edge.
  always_comb begin
    a     = bus.rd;
    b     = bus.rr;
    cin   = bus.cin_en & bus.flags_in[F_C];
    sum_w = '0;
    sum_n = '0;
    r     = '0;
    c_f   = bus.flags_in[F_C];
    h_f   = bus.flags_in[F_H];
    v_f   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sum_w = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum_n = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        r     = sum_w[W-1:0];
        if (bus.cout_en) c_f = sum_w[W];
        h_f   = sum_n[4];
        v_f   = (a[W-1] & b[W-1] & ~r[W-1]) | (~a[W-1] & ~b[W-1] & r[W-1]);
      end
      OP_SUB: begin
        // Bit W / bit 4 of the widened difference is the borrow.
        sum_w = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        sum_n = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0000, cin};
        r     = sum_w[W-1:0];
        if (bus.cout_en) c_f = sum_w[W];
        h_f   = sum_n[4];
        v_f   = (a[W-1] & ~b[W-1] & ~r[W-1]) | (~a[W-1] & b[W-1] & r[W-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NEG: begin
        r   = -a;
        c_f = (r != '0);
        v_f = (r == {1'b1, {(W-1){1'b0}}});
        h_f = r[3] | a[3];
      end
      OP_COM: begin
        r   = ~a;
        c_f = 1'b1;
      end
      OP_LSR: begin
        r   = {1'b0, a[W-1:1]};
        c_f = a[0];
        v_f = r[W-1] ^ a[0];
      end
      OP_ASR: begin
        r   = {a[W-1], a[W-1:1]};
        c_f = a[0];
        v_f = r[W-1] ^ a[0];
      end
      OP_ROR: begin
        r   = {bus.flags_in[F_C], a[W-1:1]};
        c_f = a[0];
        v_f = r[W-1] ^ a[0];
      end
      default: ;
    endcase
    z_f        = (r == '0);
    n_f        = r[W-1];
    alu_flags  = {bus.flags_in[F_I], bus.flags_in[F_T], h_f, n_f ^ v_f, v_f, n_f, z_f, c_f};
    alu_result = {{W{1'b0}}, r};
    if (bus.op > OP_MULSU) begin
      alu_flags  = bus.flags_in;
      alu_result = '0;
    end
  end

  // One partial product per cycle. The multiplicand is pre-extended to PW
  // bits (sign-extended when rd is signed) so every addition is exact mod
  // 2^PW. For MULS the multiplier MSB has negative weight, so the last
  // partial product is subtracted instead of added.
  always_comb begin
    pp       = mplier[0] ? mcand : '0;
    acc_next = ((cnt == '0) && neg_last) ? (acc - pp) : (acc + pp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      neg_last       <= 1'b0;
      mul_flags_base <= '0;
      done_q         <= 1'b0;
      result_q       <= '0;
      flags_q        <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == '0) begin
          done_q   <= 1'b1;
          result_q <= acc_next;
          flags_q  <= {mul_flags_base[7:2], (acc_next == '0), acc_next[PW-1]};
        end
      end
      if (accept) begin
        if (is_mul_op) begin
          cnt            <= CW'(W - 1);
          acc            <= '0;
          mcand          <= (bus.op == OP_MUL) ? {{W{1'b0}}, bus.rd}
                                               : {{W{bus.rd[W-1]}}, bus.rd};
          mplier         <= bus.rr;
          neg_last       <= (bus.op == OP_MULS);
          mul_flags_base <= bus.flags_in;
        end else begin
          done_q   <= 1'b1;
          result_q <= alu_result;
          flags_q  <= alu_flags;
        end
      end
    end
  end
endmodule
